// File: rtl/matvec_pkg.sv
// matvec_pkg: shared states, default Q formats and output rounding/saturation for matvec_engine
package matvec_pkg;

    localparam int DEF_MAX_ROWS   = 64;
    localparam int DEF_MAX_COLS   = 64;
    localparam int DEF_BANDWIDTH  = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_MAT   = 14;
    localparam int DEF_FRAC_VEC   = 12;
    localparam int DEF_ACC_WIDTH  = 40;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_VLOAD = 7'b000_0010,
        S_REQ   = 7'b000_0100,
        S_WAIT  = 7'b000_1000,
        S_MAC   = 7'b001_0000,
        S_OUT   = 7'b010_0000,
        S_DONE  = 7'b100_0000
    } state_t;

    // Optional round-half-up, arithmetic shift by frac, then clamp to a signed dw-bit range.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] acc,
        input  int                 frac,
        input  int                 dw,
        input  logic               rnd,
        output logic               sat
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v   = (acc + (rnd ? (64'sd1 <<< (frac - 1)) : 64'sd0)) >>> frac;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        sat = (v > hi) || (v < lo);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage

// File: rtl/matvec_dot_lanes.sv
// matvec_dot_lanes: masked lane-wise signed multiply with full-precision reduction
module matvec_dot_lanes
    import matvec_pkg::*;
#(
    parameter  int BANDWIDTH  = DEF_BANDWIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int SW         = 2 * DATA_WIDTH + $clog2(BANDWIDTH)
) (
    input  logic [BANDWIDTH*DATA_WIDTH-1:0] i_mat,
    input  logic [BANDWIDTH*DATA_WIDTH-1:0] i_vec,
    input  logic [BANDWIDTH-1:0]            i_mask,
    output logic signed [SW-1:0]            o_sum
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;

    // Masked lanes contribute zero; the sum is wide enough that no lane combination overflows.
    always_comb begin
        w_prod = '0;
        o_sum  = '0;
        for (int i = 0; i < BANDWIDTH; i++) begin
            w_prod = $signed(i_mat[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(i_vec[i*DATA_WIDTH +: DATA_WIDTH]);
            o_sum  = o_sum + (i_mask[i] ? SW'(w_prod) : SW'(0));
        end
    end

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: y = W*x over a runtime-sized W streamed from SRAM in BANDWIDTH-wide chunks
module matvec_engine
    import matvec_pkg::*;
#(
    parameter  int MAX_ROWS   = DEF_MAX_ROWS,
    parameter  int MAX_COLS   = DEF_MAX_COLS,
    parameter  int BANDWIDTH  = DEF_BANDWIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int FRAC_MAT   = DEF_FRAC_MAT,
    parameter  int FRAC_VEC   = DEF_FRAC_VEC,
    parameter  int ACC_WIDTH  = DEF_ACC_WIDTH,
    localparam int RW         = $clog2(MAX_ROWS + 1),
    localparam int CW         = $clog2(MAX_COLS + 1),
    localparam int VAW        = $clog2(MAX_COLS),
    localparam int MAW        = $clog2(MAX_ROWS * MAX_COLS),
    localparam int ROWW       = $clog2(MAX_ROWS),
    localparam int LW         = BANDWIDTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [RW-1:0]         i_num_rows,
    input  logic [CW-1:0]         i_num_cols,
    input  logic                  i_round_en,
    input  logic                  i_vector_write_enable,
    input  logic [VAW-1:0]        i_vector_base_addr,
    input  logic [LW-1:0]         i_vector_in,
    output logic [MAW-1:0]        o_matrix_addr,
    output logic                  o_matrix_enable,
    input  logic [LW-1:0]         i_matrix_data,
    input  logic                  i_matrix_ready,
    output logic [DATA_WIDTH-1:0] o_result_out,
    output logic [ROWW-1:0]       o_result_row,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sat_flag
);

    localparam int XW    = $clog2(MAX_COLS + BANDWIDTH);
    localparam int SW    = 2 * DATA_WIDTH + $clog2(BANDWIDTH);
    // Products carry FRAC_MAT+FRAC_VEC fraction bits; results carry FRAC_VEC.
    localparam int SHIFT = (FRAC_MAT + FRAC_VEC) - FRAC_VEC;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [RW-1:0]                r_num_rows;
    logic [RW-1:0]                r_row;
    logic [CW-1:0]                r_num_cols;
    logic [XW-1:0]                r_col;
    logic                         r_round;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic [LW-1:0]                r_mat;
    logic [LW-1:0]                w_vec_slice;
    logic [BANDWIDTH-1:0]         w_mask;
    logic signed [SW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0]        r_vbuf [MAX_COLS];
    logic [DATA_WIDTH-1:0]        w_res;
    logic                         w_res_sat;
    logic [DATA_WIDTH-1:0]        r_result_out;
    logic [ROWW-1:0]              r_result_row;
    logic                         r_result_valid;
    logic                         r_sat;
    logic                         w_vload_last;
    logic                         w_last_chunk;
    logic                         w_accept;

    assign w_vload_last    = (XW'(i_vector_base_addr) + XW'(BANDWIDTH)) >= XW'(r_num_cols);
    assign w_last_chunk    = (r_col + XW'(BANDWIDTH)) >= XW'(r_num_cols);
    assign w_accept        = r_result_valid && i_result_ready;
    assign w_acc_next      = r_acc + ACC_WIDTH'(w_sum);
    assign o_matrix_enable = r_state == S_REQ;
    assign o_matrix_addr   = (r_state == S_REQ) ? MAW'(r_row) * MAW'(r_num_cols) + MAW'(r_col) : '0;
    assign o_result_out    = r_result_out;
    assign o_result_row    = r_result_row;
    assign o_result_valid  = r_result_valid;
    assign o_busy          = r_state != S_IDLE;
    assign o_done          = r_state == S_DONE;
    assign o_sat_flag      = r_sat;

    // Vector buffer: only written while loading, lanes beyond the active column count are dropped.
    always_ff @(posedge clk) begin
        if (r_state == S_VLOAD && i_vector_write_enable)
            for (int i = 0; i < BANDWIDTH; i++)
                if ((XW'(i_vector_base_addr) + XW'(i)) < XW'(r_num_cols))
                    r_vbuf[i_vector_base_addr + VAW'(i)] <= i_vector_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Select the vector lanes aligned with the current chunk and mask columns past the row end.
    always_comb begin
        w_vec_slice = '0;
        w_mask      = '0;
        for (int i = 0; i < BANDWIDTH; i++) begin
            w_mask[i]                             = (r_col + XW'(i)) < XW'(r_num_cols);
            w_vec_slice[i*DATA_WIDTH +: DATA_WIDTH] = r_vbuf[VAW'(r_col + XW'(i))];
        end
    end

    matvec_dot_lanes #(
        .BANDWIDTH  (BANDWIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dot (
        .i_mat  (r_mat),
        .i_vec  (w_vec_slice),
        .i_mask (w_mask),
        .o_sum  (w_sum)
    );

    // Round and clamp the row total as it completes so the result is ready on S_OUT entry.
    always_comb begin
        w_res_sat = 1'b0;
        w_res     = DATA_WIDTH'(round_sat(64'(w_acc_next), SHIFT, DATA_WIDTH, r_round, w_res_sat));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = (i_num_rows == '0 || i_num_cols == '0) ? S_DONE : S_VLOAD;
            S_VLOAD: if (i_vector_write_enable && w_vload_last) w_state_next = S_REQ;
            S_REQ:   w_state_next = S_WAIT;
            S_WAIT:  if (i_matrix_ready) w_state_next = S_MAC;
            S_MAC:   w_state_next = w_last_chunk ? S_OUT : S_REQ;
            S_OUT:   if (w_accept) w_state_next = ((r_row + RW'(1)) < r_num_rows) ? S_REQ : S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run configuration, row/column progress, accumulation and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_rows     <= '0;
            r_num_cols     <= '0;
            r_round        <= 1'b0;
            r_row          <= '0;
            r_col          <= '0;
            r_acc          <= '0;
            r_mat          <= '0;
            r_result_out   <= '0;
            r_result_row   <= '0;
            r_result_valid <= 1'b0;
            r_sat          <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_num_rows <= i_num_rows;
                r_num_cols <= i_num_cols;
                r_round    <= i_round_en;
                r_row      <= '0;
                r_col      <= '0;
                r_acc      <= '0;
                r_sat      <= 1'b0;
            end
            if (r_state == S_WAIT && i_matrix_ready)
                r_mat <= i_matrix_data;
            if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_col <= r_col + XW'(BANDWIDTH);
                if (w_last_chunk) begin
                    r_result_valid <= 1'b1;
                    r_result_out   <= w_res;
                    r_result_row   <= r_row[ROWW-1:0];
                    r_sat          <= r_sat | w_res_sat;
                end
            end
            if (r_state == S_OUT && w_accept) begin
                r_result_valid <= 1'b0;
                r_row          <= r_row + RW'(1);
                r_col          <= '0;
                r_acc          <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: scoreboard bench for matvec_engine with BANDWIDTH=4 and a one-cycle SRAM model
module tb_matvec_engine;

    localparam int BW = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [6:0]        num_rows = '0;
    logic [6:0]        num_cols = '0;
    logic              round_en = 1'b0;
    logic              vwe = 1'b0;
    logic [5:0]        vbase = '0;
    logic [BW*DW-1:0]  vin = '0;
    logic [11:0]       maddr;
    logic              men;
    logic [BW*DW-1:0]  mdata = '0;
    logic              mready = 1'b0;
    logic [15:0]       rout;
    logic [5:0]        rrow;
    logic              rvalid;
    logic              rready = 1'b1;
    logic              busy;
    logic              done;
    logic              sat;

    logic [15:0]       wmem [256];
    logic [15:0]       xv [64];
    int                n_checks = 0;
    int                n_errors = 0;
    int                lat = 0;
    int                done_cnt = 0;
    int                valid_cnt = 0;
    int                exp_row [$];
    logic [15:0]       exp_val [$];
    int                fq [$];

    always #5 clk = ~clk;

    matvec_engine #(
        .MAX_ROWS  (64),
        .MAX_COLS  (64),
        .BANDWIDTH (BW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_start               (start),
        .i_num_rows            (num_rows),
        .i_num_cols            (num_cols),
        .i_round_en            (round_en),
        .i_vector_write_enable (vwe),
        .i_vector_base_addr    (vbase),
        .i_vector_in           (vin),
        .o_matrix_addr         (maddr),
        .o_matrix_enable       (men),
        .i_matrix_data         (mdata),
        .i_matrix_ready        (mready),
        .o_result_out          (rout),
        .o_result_row          (rrow),
        .o_result_valid        (rvalid),
        .i_result_ready        (rready),
        .o_busy                (busy),
        .o_done                (done),
        .o_sat_flag            (sat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden row value: exact integer dot product, optional +0.5 LSB, shift, clamp.
    task automatic model_row(input int r, input int nc, input bit rnd, output logic [15:0] val, output bit s);
        longint acc;
        acc = 0;
        for (int c = 0; c < nc; c++)
            acc += longint'($signed(wmem[r*nc+c])) * longint'($signed(xv[c]));
        if (rnd) acc += 8192;
        acc = acc >>> 14;
        s = (acc > 32767) || (acc < -32768);
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        val = acc[15:0];
    endtask

    // Matrix SRAM: answers each read request after 1+lat cycles with one ready pulse.
    initial forever begin
        int a;
        @(negedge clk);
        if (men) begin
            a = int'(maddr);
            fq.push_back(a);
            chk("no_fetch_while_result_pending", rvalid, 0);
            repeat (lat) @(posedge clk);
            @(posedge clk);
            #1;
            for (int i = 0; i < BW; i++)
                mdata[i*DW +: DW] = (a + i < 256) ? wmem[a+i] : 16'h0;
            mready = 1'b1;
            @(posedge clk);
            #1;
            mready = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted result.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (rvalid) valid_cnt++;
        if (rvalid && rready) begin
            if (exp_val.size() == 0)
                chk("unexpected_result", exp_val.size(), 1);
            else begin
                chk("result_row", rrow, exp_row.pop_front());
                chk("result_val", rout, exp_val.pop_front());
            end
        end
    end

    task automatic kick(input int nr, input int nc, input bit rnd);
        @(posedge clk);
        #1;
        num_rows = 7'(nr);
        num_cols = 7'(nc);
        round_en = rnd;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (nr > 0 && nc > 0) begin
            for (int b = 0; b < nc; b += BW) begin
                vwe   = 1'b1;
                vbase = 6'(b);
                for (int i = 0; i < BW; i++)
                    vin[i*DW +: DW] = (b + i < 64) ? xv[b+i] : 16'h0;
                @(posedge clk);
                #1;
            end
            vwe = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk({name, "_done_seen"}, seen, 1);
    endtask

    task automatic run_dir(input string name, input int nc, input bit rnd, input logic [15:0] e, input bit e_sat);
        exp_row.push_back(0);
        exp_val.push_back(e);
        kick(1, nc, rnd);
        wait_done(name);
        chk({name, "_drained"}, exp_val.size(), 0);
        chk({name, "_sat"}, sat, e_sat);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_men"}, men, 0);
        chk({name, "_maddr"}, maddr, 0);
        chk({name, "_rout"}, rout, 0);
        chk({name, "_rrow"}, rrow, 0);
        chk({name, "_rvalid"}, rvalid, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_sat"}, sat, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int v0;
        bit seen;
        bit rnd;
        bit s;
        bit s_any;
        logic [15:0] v;
        for (int i = 0; i < 256; i++) wmem[i] = 16'h0;
        for (int i = 0; i < 64; i++) xv[i] = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1x3: 1.0*1.0 + 0.5*2.0 + 0*3.0 = 2.0; wmem[3] is junk that must be masked.
        wmem[0] = 16'h4000; wmem[1] = 16'h2000; wmem[2] = 16'h0000; wmem[3] = 16'h7FFF;
        xv[0] = 16'h1000; xv[1] = 16'h2000; xv[2] = 16'h3000; xv[3] = 16'h7FFF;
        d0 = done_cnt;
        run_dir("basic", 3, 1'b0, 16'h2000, 1'b0);
        @(posedge clk);
        #1;
        chk("basic_done_once", done_cnt - d0, 1);
        chk("basic_done_low", done, 0);
        chk("basic_idle", busy, 0);

        // Rounding: 0.5*2^-12 product rounds up to 1 LSB or truncates to 0; negative half rounds to 0.
        wmem[0] = 16'h2000; xv[0] = 16'h0001;
        run_dir("round_up", 1, 1'b1, 16'h0001, 1'b0);
        run_dir("truncate", 1, 1'b0, 16'h0000, 1'b0);
        wmem[0] = 16'hE000;
        run_dir("round_neg", 1, 1'b1, 16'h0000, 1'b0);

        // Saturation both directions.
        for (int i = 0; i < 8; i++) begin wmem[i] = 16'h7FFF; xv[i] = 16'h7FFF; end
        run_dir("sat_pos", 8, 1'b1, 16'h7FFF, 1'b1);
        for (int i = 0; i < 8; i++) wmem[i] = 16'h8000;
        run_dir("sat_neg", 8, 1'b1, 16'h8000, 1'b1);

        // Backpressure on a 2x4 run: row0 = 1.0*1.0, row1 = 1.0*2.0.
        for (int i = 0; i < 8; i++) wmem[i] = 16'h0;
        wmem[0] = 16'h4000; wmem[5] = 16'h4000;
        xv[0] = 16'h1000; xv[1] = 16'h2000; xv[2] = 16'h0; xv[3] = 16'h0;
        exp_row.push_back(0); exp_val.push_back(16'h1000);
        exp_row.push_back(1); exp_val.push_back(16'h2000);
        rready = 1'b0;
        kick(2, 4, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = rvalid;
        end
        chk("bp_valid_seen", seen, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_val_stable", rout, 16'h1000);
            chk("bp_row_stable", rrow, 0);
            chk("bp_valid_held", rvalid, 1);
            chk("bp_no_fetch", men, 0);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        wait_done("bp");
        chk("bp_drained", exp_val.size(), 0);
        chk("bp_sat_cleared", sat, 0);

        // Zero dimensions go straight to done without results.
        v0 = valid_cnt;
        for (int z = 0; z < 2; z++) begin
            @(posedge clk);
            #1;
            num_rows = (z == 0) ? 7'd0 : 7'd2;
            num_cols = (z == 0) ? 7'd3 : 7'd0;
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            #2;
            chk("zero_dim_done", done, 1);
            @(posedge clk);
            #1;
            chk("zero_dim_idle", busy, 0);
        end
        chk("zero_dim_no_valid", valid_cnt - v0, 0);

        // Reset while waiting on the SRAM, then a clean run.
        wmem[0] = 16'h4000; wmem[1] = 16'h2000; wmem[2] = 16'h0000;
        xv[0] = 16'h1000; xv[1] = 16'h2000; xv[2] = 16'h3000;
        lat = 6;
        kick(1, 3, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = men;
        end
        chk("rst_fetch_seen", seen, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (lat + 4) @(posedge clk);
        lat = 0;
        run_dir("after_reset", 3, 1'b0, 16'h2000, 1'b0);

        // 3x5 runs against the golden model, with fetch address checks.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 15; i++) wmem[i] = 16'($urandom);
            for (int i = 0; i < 5; i++) xv[i] = 16'($urandom);
            rnd   = 1'($urandom_range(0, 1));
            lat   = $urandom_range(0, 1);
            s_any = 1'b0;
            for (int r = 0; r < 3; r++) begin
                model_row(r, 5, rnd, v, s);
                s_any |= s;
                exp_row.push_back(r);
                exp_val.push_back(v);
            end
            fq.delete();
            kick(3, 5, rnd);
            wait_done("rand");
            chk("rand_drained", exp_val.size(), 0);
            chk("rand_sat", sat, s_any);
            chk("rand_fetch_count", fq.size(), 6);
            for (int k = 0; k < fq.size() && k < 6; k++)
                chk("rand_fetch_addr", fq[k], (k / 2) * 5 + (k % 2) * 4);
        end
        lat = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Parametrised fixed-point matrix-vector multiplier for the LSTM datapath: computes y = W·x for a runtime-sized W (up to MAX_ROWS × MAX_COLS) streamed from matrix SRAM in BANDWIDTH-wide chunks against a locally buffered vector. It is the next generation of the existing matvec multiplier and adds:
- full-precision lane reduction with configurable Q formats;
- round-to-nearest and saturation on output;
- a valid/ready result handshake with backpressure;
- zero-dimension handling;
- a saturation status flag.

## Interface
Parameters:
- MAX_ROWS, 64, maximum matrix rows
- MAX_COLS, 64, maximum matrix columns
- BANDWIDTH, 16, lanes per matrix fetch
- DATA_WIDTH, 16, element width (matrix, vector, result)
- FRAC_MAT, 14, matrix fraction bits (Q2.14)
- FRAC_VEC, 12, vector and result fraction bits (Q4.12)
- ACC_WIDTH, 40, accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; honoured only in S_IDLE
- num_rows  in  $clog2(MAX_ROWS+1)  rows, 0..MAX_ROWS; sampled at start
- num_cols  in  $clog2(MAX_COLS+1)  columns, 0..MAX_COLS; sampled at start
- round_en  in  1  1 = round half up, 0 = truncate; sampled at start
- vector_write_enable  in  1  vector chunk write strobe
- vector_base_addr  in  $clog2(MAX_COLS)  column index of lane 0
- vector_in  in  BANDWIDTH×DATA_WIDTH  signed Q4.12 lanes
- matrix_addr  out  $clog2(MAX_ROWS*MAX_COLS)  row×num_cols + col
- matrix_enable  out  1  one-cycle read request
- matrix_data  in  BANDWIDTH×DATA_WIDTH  signed Q2.14 lanes
- matrix_ready  in  1  matrix_data valid
- result_out  out  DATA_WIDTH  signed Q4.12 row result
- result_row  out  $clog2(MAX_ROWS)  row index of result_out
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  state ≠ S_IDLE
- done  out  1  one-cycle pulse at end of run
- sat_flag  out  1  sticky: some row saturated in the current run

## Operation
States: S_IDLE, S_VLOAD, S_REQ, S_WAIT, S_MAC, S_OUT, S_DONE.
- S_IDLE: on start, latch the dimensions and round_en, then clear row, col, acc and sat_flag. If num_rows==0 or num_cols==0, go to S_DONE; otherwise go to S_VLOAD.
- S_VLOAD: vector writes are accepted only in this state; writes in any other state are ignored. Lane i is written when base+i < num_cols. When base+BANDWIDTH ≥ num_cols, the buffer is complete and the next state is S_REQ.
- S_REQ: matrix_enable=1 and matrix_addr is valid for this cycle only; next state is S_WAIT.
- S_WAIT: hold until matrix_ready; matrix_data lanes are registered on that cycle; next state is S_MAC.
- S_MAC: lanes with col+i ≥ num_cols contribute 0. Each product is signed 2·DATA_WIDTH bits with FRAC_MAT+FRAC_VEC fraction bits. All BANDWIDTH products are summed at full precision and sign-extended into acc (ACC_WIDTH). col += BANDWIDTH. If col+BANDWIDTH ≥ num_cols, go to S_OUT; otherwise go to S_REQ.
- S_OUT: result = (acc + (round_en ? 2^(FRAC_MAT−1) : 0)) >>> FRAC_MAT (arithmetic shift), saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. Any clamp sets sat_flag. When result_valid && result_ready: row++, col=0, acc=0. Next state is S_REQ if row+1 < num_rows, otherwise S_DONE.
- S_DONE: done=1 for one cycle; next state is S_IDLE. sat_flag holds until the next start.
- Reset mid-run returns to S_IDLE with all outputs at their reset values. Vector buffer contents are undefined after reset.

## Timing
- Reset values: matrix_enable=0, matrix_addr=0, result_out=0, result_row=0, result_valid=0, busy=0, done=0, sat_flag=0.
- Per chunk, with a one-cycle SRAM: S_REQ(1) + S_WAIT(≥1) + S_MAC(1). Minimum is 3 cycles per chunk, plus 1 cycle per row in S_OUT when result_ready is held high.
- result_valid is registered: asserted on S_OUT entry and deasserted the cycle after the handshake. result_out and result_row stay stable while valid && !ready.
- No matrix fetch occurs while a result is stalled.
- start during busy is ignored.

## Structure
- matvec_pkg: state_t (one-hot enum), the rounding and saturation function, and the default Q-format localparams.
- Sub-module matvec_dot_lanes: combinational BANDWIDTH-lane masked multiply plus adder tree. Inputs are the lanes, vector slice, and valid mask; output is the full-precision sum.

## Test plan
- Test configuration: BANDWIDTH=4. Run with 1×3 W=[0x4000, 0x2000, 0] and x=[0x1000, 0x2000, 0x3000] → single result 0x2000 (2.0), row 0; sat_flag=0; done pulses once.
- 3×5 W with random values, 1000 random runs → each row matches a golden model to the bit. Exactly 2 fetches per row, and matrix_addr = row·5 + {0, 4}.
- Rounding: W=[0x2000], x=[0x0001] → result 0x0001 with round_en=1, 0x0000 with round_en=0. Negative case: W=[0xE000], x=[0x0001] with round_en=1 → result 0x0000.
- Saturation: 1×8 W of 0x7FFF, x of 0x7FFF → result 0x7FFF and sat_flag=1. The same run with W of 0x8000 → result 0x8000.
- Backpressure: hold result_ready=0 for 5 cycles on row 0 of a 2-row run → result stable, no matrix_enable until accepted, row 1 follows.
- num_rows=0 → S_DONE within 2 cycles, no result_valid. Assert rst_n mid-S_WAIT → all outputs at reset values; a fresh run then completes correctly.
